// File: rtl/contador_arbitro.sv
// Two-requester arbiter that grants a shared 3-bit up/down counter for a latched number of steps.
// Build option CONTADOR_ARBITRO_RR_EN: round-robin arbitration (default build is fixed priority, requester 0 first).
module contador_arbitro #(
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             dir0,
    input  logic [LEN_W-1:0] len0,
    input  logic             req1,
    input  logic             dir1,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             y0,
    output logic             y1,
    output logic             y2
);

    // state | meaning
    // IDLE  | no owner; waiting for req0/req1
    // RUN   | owner holds the counter; one step per edge while rem != 0
    // DONE  | owner's done pulse is high; returns to IDLE next edge
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       cnt, cnt_nx;
    logic [LEN_W-1:0] rem, rem_nx;
    logic             dir_q, dir_nx;
    logic             owner, owner_nx;
    logic             gnt0_nx, gnt1_nx, done0_nx, done1_nx;
    logic             win;
    logic             grant;

    assign grant = (state == IDLE) && (req0 || req1);

`ifdef CONTADOR_ARBITRO_RR_EN
    logic last;

    // On a tie the requester not granted last wins
    assign win = (req0 && req1) ? ~last : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (grant) begin
            last <= win;
        end
    end
`else
    assign win = req1 && !req0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rem_nx   = rem;
        dir_nx   = dir_q;
        owner_nx = owner;
        gnt0_nx  = gnt0;
        gnt1_nx  = gnt1;
        done0_nx = 1'b0;
        done1_nx = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    owner_nx = win;
                    dir_nx   = win ? dir1 : dir0;
                    rem_nx   = win ? len1 : len0;
                    gnt0_nx  = !win;
                    gnt1_nx  = win;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (rem != '0) begin
                    cnt_nx = dir_q ? cnt + 3'd1 : cnt - 3'd1;
                    rem_nx = rem - LEN_W'(1);
                end
                // rem of 1 is the final step; rem of 0 means a zero-length run
                if (rem <= LEN_W'(1)) begin
                    gnt0_nx  = 1'b0;
                    gnt1_nx  = 1'b0;
                    done0_nx = !owner;
                    done1_nx = owner;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            rem   <= '0;
            dir_q <= 1'b0;
            owner <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rem   <= rem_nx;
            dir_q <= dir_nx;
            owner <= owner_nx;
            gnt0  <= gnt0_nx;
            gnt1  <= gnt1_nx;
            done0 <= done0_nx;
            done1 <= done1_nx;
        end
    end

    assign busy = (state != IDLE);
    assign y0   = cnt[0];
    assign y1   = cnt[1];
    assign y2   = cnt[2];

endmodule

// File: tb/tb_contador_arbitro.sv
// Bench for contador_arbitro: run-timeline model checked every cycle, plus directed literal checks.
// Honours CONTADOR_ARBITRO_RR_EN for the expected arbitration order.
module tb_contador_arbitro;

    localparam int LEN_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0, dir0 = 1'b0, req1 = 1'b0, dir1 = 1'b0;
    logic [LEN_W-1:0] len0 = '0, len1 = '0;
    logic             gnt0, gnt1, done0, done1, busy, y0, y1, y2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    contador_arbitro #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .dir0(dir0), .len0(len0),
        .req1(req1), .dir1(dir1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .busy(busy), .y0(y0), .y1(y1), .y2(y2)
    );

    always #5 clk = ~clk;

    // Model: a run granted at edge k with length L spans max(L,1) grant cycles;
    // t counts edges since the grant, y = base +/- min(t, L) modulo 8.
    int m_act = 0, m_t = 0, m_span = 0, m_len = 0, m_base = 0, m_y = 0, m_own = 0, m_last = 1;
    bit m_dir = 1'b0;

    initial begin : model
        int n, w;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_act = 0; m_y = 0; m_last = 1;
            end else if (m_act != 0) begin
                m_t = m_t + 1;
                if (m_t > m_span) begin
                    m_act = 0;
                end else begin
                    n = (m_t < m_len) ? m_t : m_len;
                    m_y = m_dir ? (m_base + n) % 8 : (m_base - n + 8) % 8;
                end
            end else if (req0 || req1) begin
`ifdef CONTADOR_ARBITRO_RR_EN
                w = (req0 && req1) ? (m_last == 1 ? 0 : 1) : (req1 ? 1 : 0);
`else
                w = req0 ? 0 : 1;
`endif
                m_last = w;
                m_own  = w;
                m_act  = 1;
                m_t    = 0;
                m_len  = (w == 0) ? int'(len0) : int'(len1);
                m_dir  = (w == 0) ? dir0 : dir1;
                m_span = (m_len == 0) ? 1 : m_len;
                m_base = m_y;
            end
        end
    end

    initial begin : compare
        logic [7:0] e, a;
        bit g, d;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                g = (m_act != 0) && (m_t < m_span);
                d = (m_act != 0) && (m_t == m_span);
                e = {g && m_own == 0, g && m_own == 1, d && m_own == 0, d && m_own == 1,
                     m_act != 0, 3'(m_y)};
                a = {gnt0, gnt1, done0, done1, busy, y2, y1, y0};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_model @%0t: got gnt/done/busy/y=%b required %b", $time, a, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int yval();
        return int'({y2, y1, y0});
    endfunction

    // Runs one request to completion; trace packs post-step y values as octal digits.
    task automatic run_req(input int who, input bit dir, input int len,
                           output int trace, output int gcyc, output int ndone, output int busy_after);
        bit prev_g, got, g, d;
        @(negedge clk);
        if (who == 0) begin req0 = 1; dir0 = dir; len0 = LEN_W'(len); end
        else          begin req1 = 1; dir1 = dir; len1 = LEN_W'(len); end
        trace = 0; gcyc = 0; ndone = 0; prev_g = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            g = (who == 0) ? gnt0 : gnt1;
            d = (who == 0) ? done0 : done1;
            if (prev_g) trace = trace * 8 + yval();
            prev_g = g;
            if (g) gcyc++;
            if (d) begin ndone++; got = 1; end
        end
        if (!got) chk("run_req_timeout", 0, 1);
        req0 = 0; req1 = 0;
        @(negedge clk);
        if (done0 || done1) ndone++;
        busy_after = int'(busy);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int tr, gc, nd, ba, order, ngr, need, first;
        bit pg0, pg1, got;

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({gnt0, gnt1, done0, done1, busy, y2, y1, y0}), 0);
        chk_on = 1;
        rst = 0;

        run_req(0, 1, 3, tr, gc, nd, ba);
        chk("up3_trace", tr, 'o123);
        chk("up3_gnt_cycles", gc, 3);
        chk("up3_done_pulses", nd, 1);
        chk("up3_busy_after", ba, 0);

        run_req(0, 1, 3, tr, gc, nd, ba);
        chk("up3_to6_trace", tr, 'o456);

        run_req(1, 1, 4, tr, gc, nd, ba);
        chk("wrap_up_trace", tr, 'o7012);
        chk("wrap_up_gnt_cycles", gc, 4);

        run_req(0, 0, 2, tr, gc, nd, ba);
        chk("down_to0_trace", tr, 'o10);

        run_req(1, 0, 2, tr, gc, nd, ba);
        chk("wrap_down_trace", tr, 'o76);
        chk("wrap_down_done_pulses", nd, 1);

        run_req(0, 1, 0, tr, gc, nd, ba);
        chk("len0_gnt_cycles", gc, 1);
        chk("len0_y_unchanged", tr, 'o6);
        chk("len0_done_pulses", nd, 1);

        // Inputs changed and req dropped right after the grant must not affect the run
        @(negedge clk);
        req0 = 1; dir0 = 1; len0 = 3'd4;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (gnt0) got = 1;
        end
        chk("latch_grant_seen", int'(got), 1);
        dir0 = 0; len0 = 3'd1; req0 = 0;
        tr = 0; pg0 = 1; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (pg0) tr = tr * 8 + yval();
            pg0 = gnt0;
            if (done0) got = 1;
        end
        chk("latch_trace", tr, 'o7012);
        @(negedge clk);

        // Reset mid-run aborts without a done pulse
        req0 = 1; dir0 = 1; len0 = 3'd5;
        repeat (3) @(negedge clk);
        rst = 1; req0 = 0;
        @(negedge clk);
        chk("abort_outputs", int'({gnt0, gnt1, done0, done1, busy, y2, y1, y0}), 0);
        rst = 0;

        // Both requesters held high with len 1 each; record grant order as hex digits (who+1)
        req0 = 1; dir0 = 1; len0 = 3'd1;
        req1 = 1; dir1 = 1; len1 = 3'd1;
`ifdef CONTADOR_ARBITRO_RR_EN
        need = 4;
`else
        need = 3;
`endif
        order = 0; ngr = 0; pg0 = 0; pg1 = 0; first = -1;
        for (int c = 0; c < 60 && ngr < need; c++) begin
            @(negedge clk);
            if (gnt0 && !pg0) begin order = order * 16 + 1; ngr++; if (first < 0) first = 0; end
            if (gnt1 && !pg1) begin order = order * 16 + 2; ngr++; if (first < 0) first = 1; end
            pg0 = gnt0; pg1 = gnt1;
        end
        chk("tie_first_after_reset", first, 0);
`ifdef CONTADOR_ARBITRO_RR_EN
        chk("tie_order_rr", order, 'h1212);
`else
        chk("tie_order_fixed", order, 'h111);
`endif
        req0 = 0; req1 = 0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (!busy) got = 1;
        end
        chk("final_idle", int'(got), 1);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_arbitro.md
CONTADOR_ARBITRO -- requirements
Module: contador_arbitro

Interface
REQ-001 Parameter LEN_W, default 3: width of each requester's step-count field.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0  input  1  requester 0 asks for a counting run; held high until done0.
REQ-005 dir0  input  1  requester 0 direction; 1 = up, 0 = down.
REQ-006 len0  input  LEN_W  requester 0 number of steps.
REQ-007 req1  input  1  requester 1 asks for a counting run; held high until done1.
REQ-008 dir1  input  1  requester 1 direction; 1 = up, 0 = down.
REQ-009 len1  input  LEN_W  requester 1 number of steps.
REQ-010 gnt0, gnt1  output  1 each  registered; owner of the counter during a run.
REQ-011 done0, done1  output  1 each  registered; one-cycle pulse when that owner's run has finished.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 y0, y1, y2  output  1 each  registered 3-bit shared count value; y0 = LSB.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE: on the first edge with req0 or req1 high, the block SHALL:
- pick a winner;
- latch the winner's dir and len into internal registers dir_q and rem;
- raise the winner's gnt;
- enter RUN.
REQ-016 RUN, rem > 1: each edge SHALL step {y2,y1,y0} by +1 (dir_q = 1) or -1 (dir_q = 0), modulo 8, and decrement rem.
REQ-017 RUN, rem == 1: the edge SHALL perform the final step, set rem to 0, drop gnt and enter DONE.
REQ-018 RUN, rem == 0 (len = 0): the next edge SHALL enter DONE with no step.
REQ-019 Latency: a request sampled at edge k with len = L > 0 SHALL give steps on edges k+1..k+L, and done is high for the cycle after edge k+L.
REQ-020 DONE: the owner's done SHALL be high for exactly one cycle; the next edge returns to IDLE.
REQ-021 The counter SHALL wrap 7 -> 0 when counting up and 0 -> 7 when counting down, with no flag.
REQ-022 During RUN, dir and len inputs SHALL be ignored, and dropping req SHALL NOT cancel the run.
REQ-023 Arbitration SHALL be round-robin using a last-grant pointer:
- if both req are high in IDLE, the requester not granted last wins;
- a single request wins regardless of the pointer.
REQ-024 The pointer SHALL update only when a grant is issued.
REQ-025 A req still high when IDLE is re-entered SHALL be treated as a new request.
REQ-026 gnt0 and gnt1 SHALL never both be high, and done0 and done1 SHALL never both be high.
REQ-027 When neither requester owns a run, y SHALL hold its value.

Reset
REQ-028 While rst is high at an edge, the block SHALL force:
- state to IDLE;
- {y2,y1,y0} = 0, rem = 0, dir_q = 0;
- gnt0 = gnt1 = done0 = done1 = busy = 0;
- last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-029 Reset SHALL override all other activity, including an abort mid-RUN or mid-DONE with no done pulse issued.

Configuration
REQ-030 Macro CONTADOR_ARBITRO_RR_EN SHALL control arbitration:
- defined: round-robin per REQ-023;
- undefined: fixed priority, requester 0 always wins ties, and the pointer logic is omitted.

Verification
REQ-031 Reset, then req0 = 1, dir0 = 1, len0 = 3 -> gnt0 high for 3 cycles; y = 1, 2, 3; done0 pulses once; busy low after.
REQ-032 y = 6, then req1 with dir1 = 1, len1 = 4 -> y = 7, 0, 1, 2 (wrap checked); y = 0, then dir1 = 0, len1 = 2 -> y = 7, 6.
REQ-033 Both req high with len = 1 each, starting from reset:
- with RR_EN: grant order 0, 1, 0, 1;
- without RR_EN: grant order 0, 0, 0.
REQ-034 req0 with len0 = 0 -> gnt0 for one cycle, y unchanged, done0 on the next cycle.
REQ-035 rst = 1 in the middle of a len0 = 5 run -> next cycle y = 0, no gnt, no done, busy = 0; then both req high -> gnt0 first.
REQ-036 During a run, toggle dir0 and len0 and drop req0 -> step count and direction match the values latched at grant.
